// File: rtl/regfile_onehot_if.sv
// Bus-side signal bundle for the one-hot register file.
// The master modport is the register selector/bus side; the slave modport is the register file.
interface regfile_onehot_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
);
  logic [NREGS-1:0] regOes;
  logic [NREGS-1:0] regLoads;
  logic [WIDTH-1:0] data_in;
  logic             pc_inc;
  logic             err_clr;
  logic [WIDTH-1:0] data_out;
  logic             bus_drive;
  logic [WIDTH-1:0] pc_out;
  logic             sel_err;

  modport master (
    output regOes, regLoads, data_in, pc_inc, err_clr,
    input  data_out, bus_drive, pc_out, sel_err
  );

  modport slave (
    input  regOes, regLoads, data_in, pc_inc, err_clr,
    output data_out, bus_drive, pc_out, sel_err
  );
endinterface

// File: rtl/regfile_onehot.sv
// Eight-entry register file addressed by one-hot enable/load vectors.
// One register doubles as the PC with its own increment path; multi-hot selects raise a sticky fault.
module regfile_onehot #(
  parameter int WIDTH    = 16,
  parameter int NREGS    = 8,
  parameter int PC_INDEX = 7,
  parameter int PC_STEP  = 1
) (
  input logic              clk,
  input logic              rst,
  regfile_onehot_if.slave  rf
);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_selErr;

  logic             w_oeNonZero;
  logic             w_oeMulti;
  logic             w_ldNonZero;
  logic             w_ldMulti;
  logic             w_oeValid;
  logic             w_ldValid;
  logic             w_pcLoad;
  logic [WIDTH-1:0] w_readData;

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign w_oeNonZero = |rf.regOes;
  assign w_ldNonZero = |rf.regLoads;
  assign w_oeMulti   = |(rf.regOes & (rf.regOes - 1'b1));
  assign w_ldMulti   = |(rf.regLoads & (rf.regLoads - 1'b1));
  assign w_oeValid   = w_oeNonZero && !w_oeMulti;
  assign w_ldValid   = w_ldNonZero && !w_ldMulti;
  assign w_pcLoad    = w_ldValid && rf.regLoads[PC_INDEX];

  always_comb begin
    w_readData = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rf.regOes[i]) begin
        w_readData = w_readData | r_regs[i];
      end
    end
    if (!w_oeValid) begin
      w_readData = '0;
    end
  end

  assign rf.data_out  = w_readData;
  assign rf.bus_drive = w_oeValid;
  assign rf.pc_out    = r_regs[PC_INDEX];
  assign rf.sel_err   = r_selErr;

  // A valid load to the PC takes priority over the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_ldValid && rf.regLoads[i]) begin
          r_regs[i] <= rf.data_in;
        end else if (i == PC_INDEX && rf.pc_inc && !w_pcLoad) begin
          r_regs[i] <= r_regs[i] + WIDTH'(PC_STEP);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_selErr <= 1'b0;
    end else if (w_oeMulti || w_ldMulti) begin
      r_selErr <= 1'b1;
    end else if (rf.err_clr) begin
      r_selErr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_onehot.sv
// Self-checking bench for regfile_onehot: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_regfile_onehot;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  logic [15:0] mdl [8];
  bit          mdlErr;

  regfile_onehot_if #(.WIDTH(16), .NREGS(8)) rf ();

  regfile_onehot #(
    .WIDTH(16), .NREGS(8), .PC_INDEX(7), .PC_STEP(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int countBits(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic logic [15:0] expRead();
    if (countBits(rf.regOes) != 1) return 16'h0000;
    for (int i = 0; i < 8; i++) if (rf.regOes[i]) return mdl[i];
    return 16'h0000;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    mdlErr = 1'b0;
  endtask

  // Apply the register-file rules to the model, then advance the DUT one edge.
  task automatic tick();
    int nL;
    int nO;
    nL = countBits(rf.regLoads);
    nO = countBits(rf.regOes);
    if (rf.pc_inc && !(nL == 1 && rf.regLoads[7])) mdl[7] = mdl[7] + 16'd1;
    if (nL == 1) begin
      for (int i = 0; i < 8; i++) if (rf.regLoads[i]) mdl[i] = rf.data_in;
    end
    if (nO > 1 || nL > 1) mdlErr = 1'b1;
    else if (rf.err_clr) mdlErr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    rf.regOes   = 8'h00;
    rf.regLoads = 8'h00;
    rf.data_in  = 16'h0000;
    rf.pc_inc   = 1'b0;
    rf.err_clr  = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1'b1;
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkCount++;
    if (rf.data_out !== 16'h0000) $display("[TB] FAIL reset_data_out: got %h expected 0000", rf.data_out);
    else passCount++;
    checkCount++;
    if (rf.bus_drive !== 1'b0) $display("[TB] FAIL reset_bus_drive: got %b expected 0", rf.bus_drive);
    else passCount++;
    checkCount++;
    if (rf.pc_out !== 16'h0000) $display("[TB] FAIL reset_pc_out: got %h expected 0000", rf.pc_out);
    else passCount++;
    checkCount++;
    if (rf.sel_err !== 1'b0) $display("[TB] FAIL reset_sel_err: got %b expected 0", rf.sel_err);
    else passCount++;
  endtask

  task automatic test_write_read();
    logic [15:0] expVal;
    for (int i = 0; i < 8; i++) begin
      idleInputs();
      rf.regLoads = 8'(1 << i);
      rf.data_in  = 16'(16'h1110 + i);
      tick();
      idleInputs();
      rf.regOes = 8'(1 << i);
      #1;
      expVal = 16'(16'h1110 + i);
      checkCount++;
      if (rf.data_out !== expVal) $display("[TB] FAIL write_read_r%0d: got %h expected %h", i, rf.data_out, expVal);
      else passCount++;
      checkCount++;
      if (rf.bus_drive !== 1'b1) $display("[TB] FAIL write_read_drive_r%0d: got %b expected 1", i, rf.bus_drive);
      else passCount++;
    end
    checkCount++;
    if (rf.pc_out !== 16'h1117) $display("[TB] FAIL write_read_pc_out: got %h expected 1117", rf.pc_out);
    else passCount++;
  endtask

  task automatic test_read_before_write();
    idleInputs();
    rf.regLoads = 8'h08;
    rf.data_in  = 16'hAAAA;
    tick();
    rf.regOes   = 8'h08;
    rf.regLoads = 8'h08;
    rf.data_in  = 16'h5555;
    #1;
    checkCount++;
    if (rf.data_out !== 16'hAAAA) $display("[TB] FAIL rbw_old: got %h expected aaaa", rf.data_out);
    else passCount++;
    tick();
    checkCount++;
    if (rf.data_out !== 16'h5555) $display("[TB] FAIL rbw_new: got %h expected 5555", rf.data_out);
    else passCount++;
  endtask

  task automatic test_pc_wrap();
    logic [15:0] expPc [3];
    expPc[0] = 16'hFFFF;
    expPc[1] = 16'h0000;
    expPc[2] = 16'h0001;
    idleInputs();
    rf.regLoads = 8'h80;
    rf.data_in  = 16'hFFFE;
    tick();
    idleInputs();
    rf.pc_inc = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkCount++;
      if (rf.pc_out !== expPc[k]) $display("[TB] FAIL pc_inc_%0d: got %h expected %h", k, rf.pc_out, expPc[k]);
      else passCount++;
    end
    rf.regLoads = 8'h80;
    rf.data_in  = 16'h0100;
    tick();
    checkCount++;
    if (rf.pc_out !== 16'h0100) $display("[TB] FAIL pc_load_wins: got %h expected 0100", rf.pc_out);
    else passCount++;
    rf.regLoads = 8'h06;
    rf.data_in  = 16'h7777;
    tick();
    checkCount++;
    if (rf.pc_out !== 16'h0101) $display("[TB] FAIL pc_inc_with_multiload: got %h expected 0101", rf.pc_out);
    else passCount++;
    idleInputs();
    rf.err_clr = 1'b1;
    tick();
    idleInputs();
  endtask

  task automatic test_multihot();
    idleInputs();
    rf.regLoads = 8'h06;
    rf.data_in  = 16'hBEEF;
    tick();
    idleInputs();
    rf.regOes = 8'h02;
    #1;
    checkCount++;
    if (rf.data_out !== 16'h1111) $display("[TB] FAIL multi_r1_kept: got %h expected 1111", rf.data_out);
    else passCount++;
    rf.regOes = 8'h04;
    #1;
    checkCount++;
    if (rf.data_out !== 16'h1112) $display("[TB] FAIL multi_r2_kept: got %h expected 1112", rf.data_out);
    else passCount++;
    checkCount++;
    if (rf.sel_err !== 1'b1) $display("[TB] FAIL multi_sel_err_set: got %b expected 1", rf.sel_err);
    else passCount++;
    rf.regOes = 8'h81;
    #1;
    checkCount++;
    if (rf.data_out !== 16'h0000) $display("[TB] FAIL multi_oe_data: got %h expected 0000", rf.data_out);
    else passCount++;
    checkCount++;
    if (rf.bus_drive !== 1'b0) $display("[TB] FAIL multi_oe_drive: got %b expected 0", rf.bus_drive);
    else passCount++;
    idleInputs();
    rf.err_clr = 1'b1;
    tick();
    rf.err_clr = 1'b0;
    checkCount++;
    if (rf.sel_err !== 1'b0) $display("[TB] FAIL err_clr: got %b expected 0", rf.sel_err);
    else passCount++;
    rf.regOes  = 8'h03;
    rf.err_clr = 1'b1;
    tick();
    idleInputs();
    checkCount++;
    if (rf.sel_err !== 1'b1) $display("[TB] FAIL set_beats_clr: got %b expected 1", rf.sel_err);
    else passCount++;
  endtask

  task automatic test_async_reset();
    idleInputs();
    rf.regLoads = 8'h20;
    rf.data_in  = 16'h1234;
    tick();
    rf.regLoads = 8'h20;
    rf.data_in  = 16'h9999;
    rf.regOes   = 8'h20;
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkCount++;
    if (rf.data_out !== 16'h0000) $display("[TB] FAIL async_r5: got %h expected 0000", rf.data_out);
    else passCount++;
    checkCount++;
    if (rf.pc_out !== 16'h0000) $display("[TB] FAIL async_pc_out: got %h expected 0000", rf.pc_out);
    else passCount++;
    checkCount++;
    if (rf.sel_err !== 1'b0) $display("[TB] FAIL async_sel_err: got %b expected 0", rf.sel_err);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if (rf.data_out !== 16'h0000) $display("[TB] FAIL reset_holds_r5: got %h expected 0000", rf.data_out);
    else passCount++;
    rst = 1'b0;
    tick();
    checkCount++;
    if (rf.data_out !== 16'h9999) $display("[TB] FAIL post_reset_write: got %h expected 9999", rf.data_out);
    else passCount++;
    idleInputs();
  endtask

  function automatic logic [7:0] randSel();
    int pick;
    pick = int'($urandom_range(0, 11));
    if (pick < 8) return 8'(1 << pick);
    if (pick < 10) return 8'h00;
    return 8'($urandom);
  endfunction

  task automatic test_random();
    logic [15:0] expData;
    for (int n = 0; n < 300; n++) begin
      rf.regOes   = randSel();
      rf.regLoads = randSel();
      rf.data_in  = 16'($urandom);
      rf.pc_inc   = ($urandom_range(0, 3) == 0);
      rf.err_clr  = ($urandom_range(0, 5) == 0);
      #1;
      expData = expRead();
      checkCount++;
      if (rf.data_out !== expData || rf.bus_drive !== (countBits(rf.regOes) == 1))
        $display("[TB] FAIL rand_read_%0d: got %h/%b expected %h/%b", n, rf.data_out, rf.bus_drive, expData, countBits(rf.regOes) == 1);
      else passCount++;
      checkCount++;
      if (rf.pc_out !== mdl[7] || rf.sel_err !== mdlErr)
        $display("[TB] FAIL rand_state_%0d: got pc %h err %b expected pc %h err %b", n, rf.pc_out, rf.sel_err, mdl[7], mdlErr);
      else passCount++;
      tick();
    end
    idleInputs();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst = 1'b1;
    idleInputs();
    modelReset();
    test_reset();
    test_write_read();
    test_read_before_write();
    test_pc_wrap();
    test_multihot();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/regfile_onehot.md
Name: regfile_onehot

Overview:
- Eight-entry general register file driven directly by the one-hot output-enable and load vectors from the register selector.
- Supplies the internal data bus on read and captures the bus on write.
- Register 7 is the program counter, with a dedicated increment path for the microsequencer.
- Also checks one-hot integrity of both select vectors and keeps a sticky fault flag.

Parameters:
- WIDTH, 16, data width of every register and of the bus.
- NREGS, 8, number of registers; width of the one-hot select vectors.
- PC_INDEX, 7, index of the register that has increment capability.
- PC_STEP, 1, value added to the PC register on each pc_inc.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- regOes  input  NREGS  one-hot output-enable vector from the register selector.
- regLoads  input  NREGS  one-hot load vector from the register selector.
- data_in  input  WIDTH  bus value to be written.
- pc_inc  input  1  increment PC register by PC_STEP this cycle.
- err_clr  input  1  synchronous clear of sel_err.
- data_out  output  WIDTH  selected register value (bus drive value).
- bus_drive  output  1  high when exactly one regOes bit is set.
- pc_out  output  WIDTH  current PC register value, always visible.
- sel_err  output  1  sticky flag: a select vector had more than one bit set.

Behaviour:
- Reset (async, while reset=1): all registers 0, sel_err 0. Consequently data_out 0, bus_drive 0, pc_out 0. Clock edges are ignored while reset is high.
- Read path is combinational, zero latency:
  - Exactly one bit of regOes set: data_out = that register, bus_drive = 1.
  - Zero bits set: data_out = 0, bus_drive = 0.
  - Two or more bits set: data_out = 0, bus_drive = 0. The read is suppressed, never OR-ed.
- Write path is registered, one-cycle latency: on the rising edge, if exactly one bit i of regLoads is set, reg[i] <= data_in. The new value is visible on data_out and pc_out from the next cycle.
- Zero load bits: no write.
- Two or more load bits: no register written; sel_err set.
- Read and write of the same register in the same cycle: data_out shows the old value; the new value appears after the edge.
- PC increment: pc_inc=1 with no load to PC_INDEX gives reg[PC_INDEX] <= reg[PC_INDEX] + PC_STEP, modulo 2^WIDTH. 16'hFFFF wraps to 16'h0000; no carry output.
- pc_inc together with a valid load to PC_INDEX: the load wins and the increment is dropped.
- pc_inc together with an invalid multi-bit load: the increment still occurs; no register is written.
- sel_err next-state logic:
  - Set if regOes or regLoads has two or more bits set at a rising edge.
  - Cleared by err_clr=1 at a rising edge.
  - Set condition wins over err_clr in the same cycle.
  - Held otherwise.
- Reset asserted mid-cycle clears all state immediately, including any pending write. The first edge after reset deasserts behaves normally.
- No internal state other than the NREGS registers and sel_err.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then 0 with all inputs 0 -> data_out=0, bus_drive=0, pc_out=0, sel_err=0.
- Write/read each register: for i=0..7, regLoads=1<<i, data_in=16'h1110+i for one edge; then regOes=1<<i -> data_out=16'h1110+i, bus_drive=1; pc_out=16'h1117 after i=7.
- Same-cycle read-before-write: reg3=16'hAAAA; regOes=regLoads=8'h08, data_in=16'h5555 -> data_out=16'hAAAA before the edge, 16'h5555 after.
- PC increment and wrap: load reg7=16'hFFFE, pc_inc=1 for 3 edges -> pc_out 16'hFFFF, 16'h0000, 16'h0001. Then pc_inc=1 with regLoads=8'h80, data_in=16'h0100 -> pc_out=16'h0100.
- Multi-hot fault: regLoads=8'h06, data_in=16'hBEEF -> reg1 and reg2 unchanged, sel_err=1 after the edge. Then regOes=8'h81 -> data_out=0, bus_drive=0. Then err_clr=1 alone -> sel_err=0 next cycle.
- Async reset mid-write: reg5=16'h1234; assert reset between edges -> reg5=0 and pc_out=0 immediately, with no wait for a clock; sel_err=0.
